// File: rtl/aes_block_loader.sv
// aes_block_loader
//   Upstream feeder for the AES core. It collects a valid/ready byte stream into the
//   128-bit key and data operands, raises read_enable, and holds the operands stable
//   until the core reports done. A frame is 16 key bytes followed by 16 data bytes.
//   A frame can skip the key bytes (data only) when a key is already loaded. If done
//   does not arrive in time, the operation is aborted.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   in_byte      stream byte, accepted when in_valid && in_ready
//   in_valid     in_byte is valid
//   in_ready     loader accepts a byte this cycle (low while busy)
//   hold_key     sampled on the first byte of a frame: 1 = data-only frame
//   done         completion strobe from the AES core
//   data, key    operands; byte i sits in bits [8i+7:8i]
//   read_enable  operands valid, start/hold the AES operation
//   busy         waiting for the AES core
//   timeout_err  one-cycle pulse when an operation is aborted on timeout
//   block_cnt    number of blocks completed with done (wraps)

module aes_block_loader #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold_key,
    input  logic             done,
    output logic [127:0]     data,
    output logic [127:0]     key,
    output logic             read_enable,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] block_cnt
);

    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // With TIMEOUT == 0 this value is unused; the timer is then free-running.
    localparam logic [TimerW-1:0] TimerLast = TimerW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLoadKey, StLoadData, StBusy} state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       data_q, data_d;
    logic               key_valid_q, key_valid_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               read_enable_q, read_enable_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   block_cnt_q, block_cnt_d;

    logic               xfer;
    logic [6:0]         byte_sel;

    assign in_ready    = (state_q != StBusy);
    assign xfer        = in_valid && in_ready;
    assign byte_sel    = {idx_q, 3'b000};

    assign data        = data_q;
    assign key         = key_q;
    assign read_enable = read_enable_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign block_cnt   = block_cnt_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        key_d         = key_q;
        data_d        = data_q;
        key_valid_d   = key_valid_q;
        timer_d       = timer_q;
        read_enable_d = read_enable_q;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        block_cnt_d   = block_cnt_q;

        case (state_q)
            StIdle: begin
                if (xfer) begin
                    idx_d = 4'd1;
                    // Key reuse only if a key has actually been loaded since reset.
                    if (hold_key && key_valid_q) begin
                        data_d[7:0] = in_byte;
                        state_d     = StLoadData;
                    end else begin
                        key_d[7:0]  = in_byte;
                        state_d     = StLoadKey;
                    end
                end
            end
            StLoadKey: begin
                if (xfer) begin
                    key_d[byte_sel +: 8] = in_byte;
                    if (idx_q == 4'd15) begin
                        idx_d       = 4'd0;
                        key_valid_d = 1'b1;
                        state_d     = StLoadData;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StLoadData: begin
                if (xfer) begin
                    data_d[byte_sel +: 8] = in_byte;
                    if (idx_q == 4'd15) begin
                        idx_d         = 4'd0;
                        timer_d       = '0;
                        read_enable_d = 1'b1;
                        busy_d        = 1'b1;
                        state_d       = StBusy;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StBusy: begin
                // done takes priority over a timeout in the same cycle.
                if (done) begin
                    read_enable_d = 1'b0;
                    busy_d        = 1'b0;
                    block_cnt_d   = block_cnt_q + CNT_W'(1);
                    state_d       = StIdle;
                end else if ((TIMEOUT != 0) && (timer_q == TimerLast)) begin
                    read_enable_d = 1'b0;
                    busy_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            key_q         <= '0;
            data_q        <= '0;
            key_valid_q   <= 1'b0;
            timer_q       <= '0;
            read_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            block_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            key_q         <= key_d;
            data_q        <= data_d;
            key_valid_q   <= key_valid_d;
            timer_q       <= timer_d;
            read_enable_q <= read_enable_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            block_cnt_q   <= block_cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Testbench for aes_block_loader: directed frames, a scoreboard of expected
// operands popped when read_enable rises, done/timeout handling and mid-frame reset.

module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic         hold_key;
    logic         done;
    logic [127:0] data;
    logic [127:0] key;
    logic         read_enable;
    logic         busy;
    logic         timeout_err;
    logic [15:0]  block_cnt;

    aes_block_loader #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .hold_key    (hold_key),
        .done        (done),
        .data        (data),
        .key         (key),
        .read_enable (read_enable),
        .busy        (busy),
        .timeout_err (timeout_err),
        .block_cnt   (block_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] k;
        logic [127:0] d;
    } op_t;

    op_t          sb[$];
    op_t          last_op;
    logic [127:0] m_key;
    bit           m_kv;
    int unsigned  m_cnt;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one byte through the following posedge.
    task automatic send(input logic [7:0] b, input logic hk);
        in_valid = 1'b1;
        in_byte  = b;
        hold_key = hk;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [127:0] k, input logic [127:0] d, input logic hk);
        bit full;
        full = !(hk && m_kv);
        if (full) begin
            for (int i = 0; i < 16; i++) send(k[8*i +: 8], hk);
            check("mid_frame_ready", in_ready, 1'b1);
            check("mid_frame_re", read_enable, 1'b0);
        end
        for (int i = 0; i < 16; i++) send(d[8*i +: 8], hk);
        in_valid = 1'b0;
        hold_key = 1'b0;
        if (full) begin
            m_key = k;
            m_kv  = 1'b1;
        end
        sb.push_back('{k: m_key, d: d});
    endtask

    // Called at the negedge right after the final data byte was accepted.
    task automatic check_start(input string tag);
        check({tag, "_re"}, read_enable, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() != 0) begin
            last_op = sb.pop_front();
            check({tag, "_key"}, key, last_op.k);
            check({tag, "_data"}, data, last_op.d);
        end
    endtask

    // Pulses done in BUSY cycle n (cycle 1 is the current one) while offering junk bytes.
    task automatic busy_then_done(input string tag, input int n);
        in_valid = 1'b1;
        in_byte  = 8'hff;
        repeat (n - 1) @(negedge clk);
        check({tag, "_re_before_done"}, read_enable, 1'b1);
        done = 1'b1;
        @(negedge clk);
        done     = 1'b0;
        in_valid = 1'b0;
        m_cnt++;
        check({tag, "_re_after"}, read_enable, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_ready_after"}, in_ready, 1'b1);
        check({tag, "_terr_after"}, timeout_err, 1'b0);
        check({tag, "_cnt"}, block_cnt, m_cnt);
        check({tag, "_key_held"}, key, last_op.k);
        check({tag, "_data_held"}, data, last_op.d);
    endtask

    task automatic reset_model();
        m_key = '0;
        m_kv  = 1'b0;
        m_cnt = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data"}, data, 128'h0);
        check({tag, "_key"}, key, 128'h0);
        check({tag, "_re"}, read_enable, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_terr"}, timeout_err, 1'b0);
        check({tag, "_cnt"}, block_cnt, 16'd0);
        check({tag, "_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        hold_key = 1'b0;
        done     = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Test 1: full frame with the FIPS-197 example operands.
        send_frame(128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b,
                   128'h340737e0_a2983131_8d305a88_a8f64332, 1'b0);
        check_start("t1");
        check("t1_key_const", key, 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b);
        check("t1_data_const", data, 128'h340737e0_a2983131_8d305a88_a8f64332);

        // Test 2: done in the 10th BUSY cycle.
        busy_then_done("t2", 10);

        // Test 3: data-only frame reuses the loaded key.
        send_frame('0, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1);
        check_start("t3");
        check("t3_key_kept", key, 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b);
        busy_then_done("t3", 2);
        check("t3_cnt_two", block_cnt, 16'd2);

        // Test 6: reset after byte 20 discards the frame and the key.
        for (int i = 0; i < 20; i++) send(8'h40 + 8'(i), 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        check_reset_state("t6");

        // Test 4: hold_key right after reset still loads a full frame.
        send_frame(128'h00112233_44556677_8899aabb_ccddeeff,
                   128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b1);
        check_start("t4");
        busy_then_done("t4", 3);

        // Test 5a: no done -> abort after 64 BUSY cycles.
        send_frame('0, 128'h11111111_22222222_33333333_44444444, 1'b1);
        check_start("t5a");
        n = 0;
        while (n < 100 && timeout_err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("t5a_terr", timeout_err, 1'b1);
        check("t5a_cycles", n, 64);
        check("t5a_re", read_enable, 1'b0);
        check("t5a_busy", busy, 1'b0);
        check("t5a_cnt", block_cnt, m_cnt);
        @(negedge clk);
        check("t5a_terr_pulse", timeout_err, 1'b0);

        // Test 5b: key kept after timeout; done in cycle 64 beats the timeout.
        send_frame('0, 128'h55555555_66666666_77777777_88888888, 1'b1);
        check_start("t5b");
        busy_then_done("t5b", 64);
        @(negedge clk);
        check("t5b_terr_late", timeout_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
